// File: rtl/rx_gearbox_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_gearbox_if
//  Description : Data/slip/block-output bundle between a 32-bit RX word
//                source and the 32-to-66 bit RX gearbox.
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_gearbox_if #(
    parameter int DATA_WIDTH = 32
);
    // Raw receive word; bit 0 is the earliest-received bit.
    logic [DATA_WIDTH-1:0] i_data;
    // Request to drop one bit and move the block boundary.
    logic                  i_slip;
    // Payload half-block; bit 0 is the earliest payload bit.
    logic [DATA_WIDTH-1:0] o_data;
    // Sync header; bit 0 is the earliest header bit.
    logic [1:0]            o_header;
    logic                  o_data_valid;
    logic                  o_header_valid;

    // Gearbox side.
    modport slave (
        input  i_data,
        input  i_slip,
        output o_data,
        output o_header,
        output o_data_valid,
        output o_header_valid
    );

    // Word source / block consumer side.
    modport master (
        output i_data,
        output i_slip,
        input  o_data,
        input  o_header,
        input  o_data_valid,
        input  o_header_valid
    );
endinterface : rx_gearbox_if
`default_nettype wire

// File: rtl/rx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : rx_gearbox
//  Description : Converts a continuous 32-bit receive stream into 66-bit
//                blocks (2 header bits + 64 payload bits) presented over two
//                output cycles, with a single-bit slip for block alignment.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_gearbox #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic   i_clk,
    input  wire logic   i_reset,
    rx_gearbox_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_BLK_W       = 66;                  // header + payload
    localparam int         c_ALL_W       = c_BLK_W + DATA_WIDTH; // stored + new word
    localparam logic [7:0] c_WORD_BITS   = 8'(DATA_WIDTH);
    localparam logic [7:0] c_FIRST_NEED  = 8'd34;               // header + half payload
    localparam logic [7:0] c_SECOND_NEED = 8'd32;               // second half payload
    localparam logic [7:0] c_MAX_COUNT   = 8'd65;

    // Block phase: which half of the 66-bit block is due next.
    typedef enum logic [0:0] {
        PH_START  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // r_buf holds r_count bits, oldest at bit 0; bits above r_count are junk.
    logic [c_BLK_W-1:0]    r_buf;
    logic [6:0]            r_count;
    phase_t                r_phase;
    logic                  r_slip_pend;

    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_header;
    logic                  r_data_valid;
    logic                  r_header_valid;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [c_BLK_W-1:0]    w_keep;
    logic [c_ALL_W-1:0]    w_all;
    logic [7:0]            w_avail;
    logic                  w_take_first;
    logic                  w_take_second;
    logic [7:0]            w_used;
    logic [7:0]            w_remain;
    logic                  w_slip_req;
    logic                  w_drop;
    logic                  w_defer;
    logic [7:0]            w_shift;
    logic [7:0]            w_next_full;
    logic [6:0]            w_next_count;
    logic [c_BLK_W-1:0]    w_next_buf;

    // Only the r_count valid stored bits take part; the rest are masked off
    // so the incoming word can be OR-ed in directly above them.
    assign w_keep  = r_buf & ~({c_BLK_W{1'b1}} << r_count);

    // Available bits in arrival order: stored bits first, then this word.
    assign w_all   = {{DATA_WIDTH{1'b0}}, w_keep}
                   | ({{c_BLK_W{1'b0}}, bus.i_data} << r_count);

    assign w_avail = {1'b0, r_count} + c_WORD_BITS;

    // Decide which half-block, if any, can be extracted this cycle.
    always_comb begin
        w_take_first  = 1'b0;
        w_take_second = 1'b0;
        w_used        = 8'd0;
        if (r_phase == PH_START) begin
            if (w_avail >= c_FIRST_NEED) begin
                w_take_first = 1'b1;
                w_used       = c_FIRST_NEED;
            end
        end else begin
            if (w_avail >= c_SECOND_NEED) begin
                w_take_second = 1'b1;
                w_used        = c_SECOND_NEED;
            end
        end
    end

    // A slip drops the oldest bit left after extraction. When nothing is
    // left it is carried over to the next edge; a new request arriving
    // while one is already carried merges with it.
    assign w_remain     = w_avail - w_used;
    assign w_slip_req   = bus.i_slip | r_slip_pend;
    assign w_drop       = w_slip_req & (w_remain != 8'd0);
    assign w_defer      = w_slip_req & (w_remain == 8'd0);

    assign w_shift      = w_used + {7'd0, w_drop};
    assign w_next_full  = w_remain - {7'd0, w_drop};
    assign w_next_count = w_next_full[6:0];
    assign w_next_buf   = c_BLK_W'(w_all >> w_shift);

    // ------------------------------------------------------------------------
    // Sequential state and registered outputs
    // ------------------------------------------------------------------------
    // Buffer/phase/slip bookkeeping and half-block output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf          <= '0;
            r_count        <= 7'd0;
            r_phase        <= PH_START;
            r_slip_pend    <= 1'b0;
            r_data         <= '0;
            r_header       <= 2'b00;
            r_data_valid   <= 1'b0;
            r_header_valid <= 1'b0;
        end else begin
            r_buf       <= w_next_buf;
            r_count     <= w_next_count;
            r_slip_pend <= w_defer;

            r_data_valid   <= w_take_first | w_take_second;
            r_header_valid <= w_take_first;

            case (r_phase)
                PH_START: begin
                    if (w_take_first) begin
                        r_header <= w_all[1:0];
                        r_data   <= w_all[DATA_WIDTH+1:2];
                        r_phase  <= PH_SECOND;
                    end
                end
                PH_SECOND: begin
                    if (w_take_second) begin
                        r_data  <= w_all[DATA_WIDTH-1:0];
                        r_phase <= PH_START;
                    end
                end
                default: r_phase <= PH_START;
            endcase
        end
    end

    assign bus.o_data         = r_data;
    assign bus.o_header       = r_header;
    assign bus.o_data_valid   = r_data_valid;
    assign bus.o_header_valid = r_header_valid;

    // ------------------------------------------------------------------------
    // Buffer occupancy must stay within one block's worth of bits.
    // ------------------------------------------------------------------------
    a_no_overflow : assert property (
        @(posedge i_clk) disable iff (i_reset) (w_next_full <= c_MAX_COUNT)
    );

endmodule : rx_gearbox
`default_nettype wire
